// File: rtl/bcd_updown_timer.sv
// N-digit BCD up/down counter with debounced buttons, run/pause control,
// wrap or saturate limits, and a multiplexed active-low seven-segment driver.
module bcd_updown_timer #(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned TICK_DIV     = 26,
  parameter int unsigned SCAN_DIV     = 15,
  parameter int unsigned DEBOUNCE_LEN = 4,
  parameter bit          SAT_MODE     = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  set,
  input  logic                  up,
  input  logic                  down,
  input  logic [4*DIGITS-1:0]   sw,
  output logic [DIGITS-1:0]     DIGIT,
  output logic [6:0]            DISPLAY,
  output logic [15:0]           led
);

  localparam int unsigned CntW = 4 * DIGITS;
  localparam int unsigned SelW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {StPause, StRun} state_e;

  // Button conditioning: index 0 en, 1 set, 2 up, 3 down
  logic [3:0]                   btn_raw;
  logic [3:0][DEBOUNCE_LEN-1:0] db_q, db_d;
  logic [3:0]                   held_q, pulse_q;

  assign btn_raw = {down, up, set, en};

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      db_d[i] = DEBOUNCE_LEN'({db_q[i], btn_raw[i]});
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_q    <= '0;
      held_q  <= '0;
      pulse_q <= '0;
    end else begin
      db_q <= db_d;
      for (int i = 0; i < 4; i++) begin
        held_q[i]  <= &db_q[i];
        pulse_q[i] <= (&db_q[i]) & ~held_q[i];
      end
    end
  end

  logic p_en, p_set, p_up, p_down;
  assign p_en   = pulse_q[0];
  assign p_set  = pulse_q[1];
  assign p_up   = pulse_q[2];
  assign p_down = pulse_q[3];

  // Core state
  state_e              state_q, state_d;
  logic [CntW-1:0]     count_q, count_d;
  logic                dir_q, dir_d;
  logic                limit_q, limit_d;
  logic [TICK_DIV-1:0] tick_q, tick_d;
  logic                tick;

  assign tick   = (state_q == StRun) && (&tick_q);
  assign tick_d = (state_q == StRun) ? tick_q + 1'b1 : '0;

  // BCD increment/decrement with ripple carry/borrow, plus clamped load value
  logic [CntW-1:0] inc_val, dec_val, load_val;
  logic            carry, borrow, at_max, at_min;

  always_comb begin
    inc_val  = count_q;
    dec_val  = count_q;
    load_val = '0;
    carry    = 1'b1;
    borrow   = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (count_q[4*i+:4] == 4'd9) begin
          inc_val[4*i+:4] = 4'd0;
        end else begin
          inc_val[4*i+:4] = count_q[4*i+:4] + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (count_q[4*i+:4] == 4'd0) begin
          dec_val[4*i+:4] = 4'd9;
        end else begin
          dec_val[4*i+:4] = count_q[4*i+:4] - 4'd1;
          borrow = 1'b0;
        end
      end
      load_val[4*i+:4] = (sw[4*i+:4] > 4'd9) ? 4'd9 : sw[4*i+:4];
    end
    at_max = carry;
    at_min = borrow;
  end

  logic do_step, step_up;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    dir_d   = dir_q;
    limit_d = limit_q;
    do_step = 1'b0;
    step_up = dir_q;

    if (p_set) begin
      count_d = load_val;
      limit_d = 1'b0;
    end else if (p_en) begin
      state_d = (state_q == StRun) ? StPause : StRun;
      if (state_q == StPause) begin
        limit_d = 1'b0;
      end
    end else if (p_up ^ p_down) begin
      dir_d = p_up;
      if (state_q == StPause) begin
        do_step = 1'b1;
        step_up = p_up;
      end
    end else if (tick) begin
      do_step = 1'b1;
    end

    if (do_step) begin
      if ((step_up && at_max) || (!step_up && at_min)) begin
        if (SAT_MODE) begin
          limit_d = 1'b1;
          state_d = StPause;
        end else begin
          count_d = step_up ? inc_val : dec_val;
        end
      end else begin
        count_d = step_up ? inc_val : dec_val;
        limit_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StPause;
      count_q <= '0;
      dir_q   <= 1'b1;
      limit_q <= 1'b0;
      tick_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      dir_q   <= dir_d;
      limit_q <= limit_d;
      tick_q  <= tick_d;
    end
  end

  // Display scan; digit outputs stay blank until the first scan wrap
  logic [SCAN_DIV-1:0] scan_q;
  logic [SelW-1:0]     sel_q;
  logic                scan_on_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_q    <= '0;
      sel_q     <= '0;
      scan_on_q <= 1'b0;
    end else begin
      scan_q <= scan_q + 1'b1;
      if (&scan_q) begin
        scan_on_q <= 1'b1;
        if (!scan_on_q || (sel_q == SelW'(DIGITS - 1))) begin
          sel_q <= '0;
        end else begin
          sel_q <= sel_q + 1'b1;
        end
      end
    end
  end

  logic [3:0] cur_digit;

  always_comb begin
    DIGIT     = '1;
    DISPLAY   = 7'b1111111;
    cur_digit = count_q[{sel_q, 2'b00} +: 4];
    if (scan_on_q) begin
      DIGIT[sel_q] = 1'b0;
      case (cur_digit)
        4'd0:    DISPLAY = 7'b1000000;
        4'd1:    DISPLAY = 7'b1111001;
        4'd2:    DISPLAY = 7'b0100100;
        4'd3:    DISPLAY = 7'b0110000;
        4'd4:    DISPLAY = 7'b0011001;
        4'd5:    DISPLAY = 7'b0010010;
        4'd6:    DISPLAY = 7'b0000010;
        4'd7:    DISPLAY = 7'b1111000;
        4'd8:    DISPLAY = 7'b0000000;
        4'd9:    DISPLAY = 7'b0010000;
        default: DISPLAY = 7'b1111111;
      endcase
    end
  end

  assign led = {13'b0, limit_q, dir_q, (state_q == StRun)};

endmodule
